treasure_frame_sequencer: RTL and testbench

Frame-level controller that sits between the camera pixel stream and the Arduino result port. It counts red and blue pixels inside a programmable window once per frame, picks a per-frame color class, and confirms that class over several consecutive frames. It then publishes a stable, sequence-numbered result to the Arduino through a valid/ack handshake. It replaces single-pixel sampling with a windowed, debounced decision.

---
 rtl/treasure_frame_sequencer_pkg.sv | 40 ++++
 rtl/treasure_frame_sequencer_window_color_counter.sv | 59 +++++
 rtl/treasure_frame_sequencer.sv | 133 +++++++++++++
 tb/tb_treasure_frame_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/treasure_frame_sequencer_pkg.sv
// Shared definitions for the treasure frame sequencer: colour class
// encoding, FSM state encoding, RESULT bit-field layout and screen size.
package treasure_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_BLUE = 2'b01,
    CLS_RED  = 2'b10
  } color_class_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_DECIDE = 2'b10
  } seq_state_t;

  localparam int SCREEN_WIDTH_DEF  = 176;
  localparam int SCREEN_HEIGHT_DEF = 144;

  localparam int RESULT_W        = 9;
  localparam int RES_COLOR_BIT   = 0;
  localparam int RES_PRESENT_BIT = 1;
  localparam int RES_SHAPE_LSB   = 2;
  localparam int RES_SHAPE_MSB   = 3;
  localparam int RES_SEQ_LSB     = 4;
  localparam int RES_SEQ_MSB     = 8;

  // Build a RESULT word from a colour class and a sequence number.
  function automatic logic [RESULT_W-1:0] pack_result(color_class_t cls,
                                                      logic [4:0] seq);
    logic [RESULT_W-1:0] r;
    r = '0;
    r[RES_COLOR_BIT]                 = (cls == CLS_RED);
    r[RES_PRESENT_BIT]               = (cls != CLS_NONE);
    r[RES_SHAPE_MSB:RES_SHAPE_LSB]   = 2'b00;
    r[RES_SEQ_MSB:RES_SEQ_LSB]       = seq;
    return r;
  endfunction

endpackage

// File: rtl/treasure_frame_sequencer_window_color_counter.sv
// Windowed red/blue pixel counter. A pixel is counted once per distinct
// coordinate: only when {x,y} differs from the previous cycle's value and
// lies inside the inclusive window. Counters saturate and clear synchronously.
module window_color_counter #(
  parameter int CNT_W  = 14,
  parameter int WIN_X0 = 40,
  parameter int WIN_X1 = 135,
  parameter int WIN_Y0 = 48,
  parameter int WIN_Y1 = 95
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             count_en,
  input  logic             clear,
  input  logic [7:0]       pixel,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam logic [9:0]       X0      = 10'(WIN_X0);
  localparam logic [9:0]       X1      = 10'(WIN_X1);
  localparam logic [9:0]       Y0      = 10'(WIN_Y0);
  localparam logic [9:0]       Y1      = 10'(WIN_Y1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [19:0] prev_xy;
  logic        new_xy;
  logic        in_win;
  logic        is_red;
  logic        is_blue;

  assign new_xy  = ({pix_x, pix_y} != prev_xy);
  assign in_win  = (pix_x >= X0) && (pix_x <= X1) && (pix_y >= Y0) && (pix_y <= Y1);
  assign is_red  = pixel[7] & ~pixel[2];
  assign is_blue = ~pixel[7] & pixel[2];

  // Track last coordinate and accumulate saturating colour counts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_xy  <= '0;
      red_cnt  <= '0;
      blue_cnt <= '0;
    end else begin
      prev_xy <= {pix_x, pix_y};
      if (clear) begin
        red_cnt  <= '0;
        blue_cnt <= '0;
      end else if (count_en && new_xy && in_win) begin
        if (is_red && (red_cnt != CNT_MAX))
          red_cnt <= red_cnt + 1'b1;
        if (is_blue && (blue_cnt != CNT_MAX))
          blue_cnt <= blue_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/treasure_frame_sequencer.sv
// Frame-level colour decision: counts window pixels per frame, classifies
// each frame, debounces the class over CONFIRM frames and publishes a
// sequence-numbered RESULT to the Arduino.
//
// Handshake: RESULT_VALID rises together with a new RESULT; RESULT is frozen
// while RESULT_VALID is 1; ACK sampled high while RESULT_VALID is 1 drops
// RESULT_VALID on the next edge; ACK while RESULT_VALID is 0 is ignored; a
// publish that would occur while RESULT_VALID is 1 is dropped, not queued.
module treasure_frame_sequencer
  import treasure_frame_sequencer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int WIN_X0        = 40,
  parameter int WIN_X1        = 135,
  parameter int WIN_Y0        = 48,
  parameter int WIN_Y1        = 95,
  parameter int THRESH        = 512,
  parameter int CONFIRM       = 3,
  parameter int CNT_W         = 14
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [7:0]          PIXEL_IN,
  input  logic [9:0]          VGA_PIXEL_X,
  input  logic [9:0]          VGA_PIXEL_Y,
  input  logic                VGA_VSYNC_NEG,
  input  logic                ACK,
  output logic [RESULT_W-1:0] RESULT,
  output logic                RESULT_VALID,
  output logic                FRAME_DONE
);

  // Window upper bounds are clamped to the visible screen.
  localparam int WX1 = (WIN_X1 < SCREEN_WIDTH)  ? WIN_X1 : SCREEN_WIDTH - 1;
  localparam int WY1 = (WIN_Y1 < SCREEN_HEIGHT) ? WIN_Y1 : SCREEN_HEIGHT - 1;
  localparam int STREAK_W = $clog2(CONFIRM + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CONFIRM);
  localparam logic [CNT_W-1:0]    THRESH_C   = CNT_W'(THRESH);

  seq_state_t          state;
  logic                vsync_prev;
  logic                frame_edge;
  logic [CNT_W-1:0]    red_cnt;
  logic [CNT_W-1:0]    blue_cnt;
  color_class_t        cand_cls;
  color_class_t        pub_cls;
  logic [STREAK_W-1:0] streak;
  logic [4:0]          seq_num;

  color_class_t        frame_cls;
  color_class_t        next_cand;
  logic [STREAK_W-1:0] next_streak;
  logic                do_publish;

  assign frame_edge = vsync_prev & ~VGA_VSYNC_NEG;

  window_color_counter #(
    .CNT_W  (CNT_W),
    .WIN_X0 (WIN_X0),
    .WIN_X1 (WX1),
    .WIN_Y0 (WIN_Y0),
    .WIN_Y1 (WY1)
  ) u_counter (
    .clk      (CLK),
    .reset_n  (RESET_N),
    .count_en (state == ST_SCAN),
    .clear    (state != ST_SCAN),
    .pixel    (PIXEL_IN),
    .pix_x    (VGA_PIXEL_X),
    .pix_y    (VGA_PIXEL_Y),
    .red_cnt  (red_cnt),
    .blue_cnt (blue_cnt)
  );

  // Frame classification, streak update and publish decision for DECIDE.
  always_comb begin
    frame_cls   = CLS_NONE;
    next_cand   = cand_cls;
    next_streak = streak;
    if ((red_cnt >= THRESH_C) && (red_cnt > blue_cnt))
      frame_cls = CLS_RED;
    else if ((blue_cnt >= THRESH_C) && (blue_cnt > red_cnt))
      frame_cls = CLS_BLUE;
    if (frame_cls == cand_cls) begin
      if (streak != STREAK_MAX)
        next_streak = streak + 1'b1;
    end else begin
      next_cand   = frame_cls;
      next_streak = STREAK_W'(1);
    end
    do_publish = (state == ST_DECIDE) && (next_streak == STREAK_MAX) &&
                 (next_cand != pub_cls) && !RESULT_VALID;
  end

  // Frame FSM, confirmation registers and Arduino handshake.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state        <= ST_IDLE;
      vsync_prev   <= 1'b0;
      cand_cls     <= CLS_NONE;
      pub_cls      <= CLS_NONE;
      streak       <= '0;
      seq_num      <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      FRAME_DONE   <= 1'b0;
    end else begin
      vsync_prev <= VGA_VSYNC_NEG;
      FRAME_DONE <= 1'b0;
      if (RESULT_VALID && ACK)
        RESULT_VALID <= 1'b0;
      case (state)
        ST_IDLE:   if (frame_edge) state <= ST_SCAN;
        ST_SCAN:   if (frame_edge) state <= ST_DECIDE;
        ST_DECIDE: begin
          state      <= ST_SCAN;
          FRAME_DONE <= 1'b1;
          cand_cls   <= next_cand;
          streak     <= next_streak;
          if (do_publish) begin
            pub_cls      <= next_cand;
            seq_num      <= seq_num + 5'd1;
            RESULT       <= pack_result(next_cand, seq_num + 5'd1);
            RESULT_VALID <= 1'b1;
          end
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_treasure_frame_sequencer.sv
// Directed bench for treasure_frame_sequencer with hand-computed expectations.
module tb_treasure_frame_sequencer;
  import treasure_frame_sequencer_pkg::*;

  localparam int WX0 = 40;
  localparam int WY0 = 48;
  localparam int WW  = 96;   // window width (40..135)
  localparam logic [7:0] PIX_RED  = 8'hE0;
  localparam logic [7:0] PIX_BLUE = 8'h07;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [7:0] pixel;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic       vsync_n;
  logic       ack;
  logic [8:0] result;
  logic       result_valid;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic rv_seen = 1'b0;

  treasure_frame_sequencer dut (
    .CLK           (clk),
    .RESET_N       (reset_n),
    .PIXEL_IN      (pixel),
    .VGA_PIXEL_X   (px_x),
    .VGA_PIXEL_Y   (px_y),
    .VGA_VSYNC_NEG (vsync_n),
    .ACK           (ack),
    .RESULT        (result),
    .RESULT_VALID  (result_valid),
    .FRAME_DONE    (frame_done)
  );

  // monitor: count FRAME_DONE pulses and note any RESULT_VALID
  always @(negedge clk) begin
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (result_valid) rv_seen = 1'b1;
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int x, input int y, input logic [7:0] p);
    @(posedge clk); #1;
    px_x  = 10'(x);
    px_y  = 10'(y);
    pixel = p;
  endtask

  // n_red red pixels then n_blue blue pixels at distinct window coords
  task automatic pixels(input int n_red, input int n_blue, input int hold);
    for (int i = 0; i < n_red + n_blue; i++)
      repeat (hold) drive(WX0 + i % WW, WY0 + i / WW, (i < n_red) ? PIX_RED : PIX_BLUE);
  endtask

  // returns #1 into the DECIDE cycle
  task automatic vsync_edge();
    @(posedge clk); #1;
    px_x = '0; px_y = '0; pixel = '0;
    vsync_n = 1'b0;
    @(posedge clk); #1;
    vsync_n = 1'b1;
  endtask

  // one frame; returns #1 into the cycle where FRAME_DONE/RESULT update
  task automatic frame(input int n_red, input int n_blue);
    pixels(n_red, n_blue, 1);
    vsync_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_ack();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; pixel = '0; px_x = '0; px_y = '0; vsync_n = 1'b1; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state
    check("reset_result", 32'(result), 32'h0);
    check("reset_valid", 32'(result_valid), 32'h0);
    check("reset_fdone", 32'(frame_done), 32'h0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));

    // first edge leaves IDLE without a decision
    vsync_edge();
    @(posedge clk); #1;
    check("idle_no_fdone", 32'(frame_done), 32'h0);
    check("idle_to_scan", 32'(dut.state), 32'(ST_SCAN));

    // three full red frames -> publish red seq 1, timeline checked
    fd_cnt = 0;
    frame(4608, 0);
    frame(4608, 0);
    check("red2_no_valid", 32'(result_valid), 32'h0);
    pixels(4608, 0, 1);
    vsync_edge();
    check("decide_valid_low", 32'(result_valid), 32'h0);
    check("decide_fdone_low", 32'(frame_done), 32'h0);
    @(posedge clk); #1;
    check("red3_fdone", 32'(frame_done), 32'h1);
    check("red3_valid", 32'(result_valid), 32'h1);
    check("red3_result", 32'(result), 32'h013);
    @(posedge clk); #1;
    check("fdone_one_cycle", 32'(frame_done), 32'h0);
    check("fdone_count3", 32'(fd_cnt), 32'd3);

    // unacked red, three blue frames -> frozen
    frame(0, 600);
    frame(0, 600);
    frame(0, 600);
    check("frozen_result", 32'(result), 32'h013);
    check("frozen_valid", 32'(result_valid), 32'h1);
    do_ack();
    check("ack_clears", 32'(result_valid), 32'h0);
    frame(0, 600);
    check("blue_result", 32'(result), 32'h022);
    check("blue_valid", 32'(result_valid), 32'h1);
    do_ack();

    // equal counts and sub-threshold red both NONE; third NONE publishes
    frame(600, 600);
    frame(511, 0);
    check("none2_no_valid", 32'(result_valid), 32'h0);
    check("none2_result", 32'(result), 32'h022);
    frame(0, 0);
    check("none_result", 32'(result), 32'h030);
    check("none_valid", 32'(result_valid), 32'h1);

    // two red frames, then reset mid-SCAN while a result is pending
    frame(600, 0);
    frame(600, 0);
    pixels(100, 0, 1);
    do_reset();
    check("rst_result", 32'(result), 32'h0);
    check("rst_valid", 32'(result_valid), 32'h0);
    check("rst_fdone", 32'(frame_done), 32'h0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    vsync_edge();
    @(posedge clk); #1;
    frame(600, 0);
    frame(600, 0);
    check("rst_red2_no_valid", 32'(result_valid), 32'h0);
    frame(600, 0);
    check("rst_red3_result", 32'(result), 32'h013);
    check("rst_red3_valid", 32'(result_valid), 32'h1);

    // out-of-window pixels ignored, held coordinates counted once
    for (int i = 0; i < 48; i++) drive(WX0 - 1, WY0 + i, PIX_RED);
    for (int i = 0; i < 48; i++) drive(WX0 + WW, WY0 + i, PIX_RED);
    for (int i = 0; i < 96; i++) drive(WX0 + i, WY0 - 1, PIX_RED);
    for (int i = 0; i < 96; i++) drive(WX0 + i, WY0 + 48, PIX_RED);
    @(posedge clk); #1;
    check("outside_red_cnt", 32'(dut.u_counter.red_cnt), 32'd0);
    drive(WX0, WY0, PIX_BLUE);
    drive(WX0 + WW - 1, WY0 + 47, PIX_BLUE);
    @(posedge clk); #1;
    check("corner_blue_cnt", 32'(dut.u_counter.blue_cnt), 32'd2);
    pixels(4608, 0, 4);
    @(posedge clk); #1;
    check("dedup_red_cnt", 32'(dut.u_counter.red_cnt), 32'd4608);
    vsync_edge();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("cleared_red_cnt", 32'(dut.u_counter.red_cnt), 32'd0);

    // alternating red/blue frames never confirm
    do_reset();
    vsync_edge();
    @(posedge clk); #1;
    fd_cnt  = 0;
    rv_seen = 1'b0;
    for (int i = 0; i < 20; i++)
      if (i % 2 == 0) frame(600, 0); else frame(0, 600);
    @(posedge clk); #1;
    check("alt_valid_never", 32'(rv_seen), 32'h0);
    check("alt_result", 32'(result), 32'h0);
    check("alt_fdone_count", 32'(fd_cnt), 32'd20);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
